// File: rtl/bcd_conv_arbiter.sv
// Round-robin share of one external binary-to-BCD converter between two requesters;
// gnt pulse -> done pulse is SETTLE_CYCLES cycles, requesters wait (level req) while busy.
module bcd_conv_arbiter #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [31:0] bin0,
   input  logic        req1,
   input  logic [31:0] bin1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [31:0] conv_bin,
   input  logic [39:0] conv_bcd,
   output logic [39:0] bcd_out,
   output logic [3:0]  ndigits,
   output logic        done0,
   output logic        done1,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       owner;
   logic       last_owner;
   logic [3:0] nd_calc;

   // Digit count of the converter output, evaluated on the capture edge.
   always_comb begin
      nd_calc = 4'd1;
      for (int i = 0; i < 10; i++) begin
         if (conv_bcd[4*i +: 4] != 4'd0) nd_calc = 4'(i + 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         conv_bin   <= 32'd0;
         bcd_out    <= 40'd0;
         ndigits    <= 4'd1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               // On a tie the requester that did not finish last wins.
               if (req0 && (!req1 || last_owner)) begin
                  conv_bin <= bin0;
                  gnt0     <= 1'b1;
                  owner    <= 1'b0;
                  cnt      <= CNT_INIT;
                  busy     <= 1'b1;
                  state    <= SETTLE;
               end else if (req1) begin
                  conv_bin <= bin1;
                  gnt1     <= 1'b1;
                  owner    <= 1'b1;
                  cnt      <= CNT_INIT;
                  busy     <= 1'b1;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  bcd_out    <= conv_bcd;
                  ndigits    <= nd_calc;
                  done0      <= ~owner;
                  done1      <= owner;
                  last_owner <= owner;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
